pkt_out_collector: RTL and testbench

//  Collects packets from NUM_SRC packet-buffer send ports onto one downstream stream.

---
 rtl/pkt_out_collector.sv | 159 +++++++++++++++
 tb/tb_pkt_out_collector.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_out_collector.sv
// pkt_out_collector: round-robin collector of packet-buffer send ports onto one FIFO-buffered stream
module pkt_out_collector #(
    parameter int NUM_SRC   = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_WORDS = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_req,
    output logic [NUM_SRC-1:0]      src_ack,
    output logic [NUM_SRC-1:0]      src_rdy,
    input  logic [NUM_SRC-1:0]      src_wr,
    input  logic [NUM_SRC-1:0]      src_bop,
    input  logic [NUM_SRC-1:0]      src_eop,
    input  logic [64*NUM_SRC-1:0]   src_data,
    input  logic [16*NUM_SRC-1:0]   src_route,
    input  logic [2*NUM_SRC-1:0]    src_neighbor,
    input  logic [NUM_SRC-1:0]      src_bypass,
    input  logic                    out_rdy,
    output logic                    out_wr,
    output logic [63:0]             out_data,
    output logic                    out_bop,
    output logic                    out_eop,
    output logic [15:0]             out_route,
    output logic [1:0]              out_neighbor,
    output logic                    out_bypass,
    output logic [31:0]             pkt_count,
    output logic [2:0]              err_flags
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, DRAIN} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        bop;
        logic        eop;
        logic [15:0] route;
        logic [1:0]  neighbor;
        logic        bypass;
    } entry_t;

    state_t          state, state_nx;
    logic [GW-1:0]   g, g_nx, rr_ptr, rr_nx, pick;
    logic            found;
    logic [15:0]     lat_route;
    logic [1:0]      lat_neighbor;
    logic            lat_bypass;
    logic [31:0]     word_cnt;
    entry_t          mem [DEPTH];
    entry_t          in_word, head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            g_req, g_wr, g_eop;
    logic            load, space, push, take;
    logic            err_norfy, err_size, err_ungrant;

    assign g_req = src_req[g];
    assign g_wr  = src_wr[g];
    assign g_eop = src_eop[g];

    assign src_ack = (state != IDLE) ? (NUM_SRC'(1) << g) : '0;
    assign src_rdy = (state == XFER && count <= CW'(DEPTH - 2)) ? src_ack : '0;

    assign in_word = {src_data[64*int'(g) +: 64], src_bop[g], g_eop, lat_route, lat_neighbor, lat_bypass};
    assign head    = (count == '0) ? in_word : mem[rd_ptr];

    // An empty FIFO lets a pushed word fall straight into the output register.
    assign load  = !out_wr || out_rdy;
    assign space = (count < CW'(DEPTH)) || load;
    assign push  = (state == XFER) && g_wr && space;
    assign take  = load && (count != '0 || push);

    assign err_norfy   = |(src_wr & src_ack & ~src_rdy);
    assign err_ungrant = |(src_wr & ~src_ack);
    assign err_size    = (push && !g_eop && word_cnt >= 32'(MAX_WORDS - 1)) ||
                         (state == XFER && !g_req && !(push && g_eop));

    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && src_req[(int'(rr_ptr) + k) % NUM_SRC]) begin
                found = 1'b1;
                pick  = GW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        state_nx = state;
        g_nx     = g;
        rr_nx    = rr_ptr;
        unique case (state)
            IDLE: begin
                g_nx     = found ? pick : g;
                state_nx = found ? GRANT : IDLE;
            end
            GRANT: state_nx = XFER;
            XFER:  state_nx = ((push && g_eop) || !g_req) ? DRAIN : XFER;
            DRAIN: begin
                rr_nx    = g_req ? rr_ptr : ((int'(g) == NUM_SRC - 1) ? '0 : g + 1'b1);
                state_nx = g_req ? DRAIN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            g            <= '0;
            rr_ptr       <= '0;
            lat_route    <= '0;
            lat_neighbor <= '0;
            lat_bypass   <= 1'b0;
            word_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_wr       <= 1'b0;
            out_data     <= '0;
            out_bop      <= 1'b0;
            out_eop      <= 1'b0;
            out_route    <= '0;
            out_neighbor <= '0;
            out_bypass   <= 1'b0;
            pkt_count    <= '0;
            err_flags    <= '0;
        end else begin
            state  <= state_nx;
            g      <= g_nx;
            rr_ptr <= rr_nx;
            if (state == GRANT) begin
                lat_route    <= src_route[16*int'(g) +: 16];
                lat_neighbor <= src_neighbor[2*int'(g) +: 2];
                lat_bypass   <= src_bypass[g];
                word_cnt     <= '0;
            end
            if (push) begin
                mem[wr_ptr] <= in_word;
                wr_ptr      <= wr_ptr + 1'b1;
                word_cnt    <= word_cnt + 1'b1;
            end
            if (take)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(take);
            if (load)
                out_wr <= take;
            if (take)
                {out_data, out_bop, out_eop, out_route, out_neighbor, out_bypass} <= head;
            if (out_wr && out_rdy && out_eop)
                pkt_count <= pkt_count + 1'b1;
            err_flags <= err_flags | {err_ungrant, err_size, err_norfy};
        end
    end
endmodule

// File: tb/tb_pkt_out_collector.sv
// tb_pkt_out_collector: randomized source agents with a word scoreboard for pkt_out_collector
module tb_pkt_out_collector;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int MW = 255;

    typedef struct packed {
        logic [63:0] d;
        logic        b;
        logic        e;
        logic [15:0] r;
        logic [1:0]  n;
        logic        y;
    } word_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    src_req, src_ack, src_rdy, src_wr, src_bop, src_eop, src_bypass;
    logic [64*N-1:0] src_data;
    logic [16*N-1:0] src_route;
    logic [2*N-1:0]  src_neighbor;
    logic            out_rdy, out_wr, out_bop, out_eop, out_bypass;
    logic [63:0]     out_data;
    logic [15:0]     out_route;
    logic [1:0]      out_neighbor;
    logic [31:0]     pkt_count;
    logic [2:0]      err_flags;

    pkt_out_collector #(.NUM_SRC(N), .DEPTH(D), .MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .src_req(src_req), .src_ack(src_ack), .src_rdy(src_rdy), .src_wr(src_wr),
        .src_bop(src_bop), .src_eop(src_eop), .src_data(src_data), .src_route(src_route),
        .src_neighbor(src_neighbor), .src_bypass(src_bypass),
        .out_rdy(out_rdy), .out_wr(out_wr), .out_data(out_data), .out_bop(out_bop),
        .out_eop(out_eop), .out_route(out_route), .out_neighbor(out_neighbor),
        .out_bypass(out_bypass), .pkt_count(pkt_count), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    word_t       exp_q[$];
    int          grant_q[$];
    int          checks, errors, cyc, exp_pkts;
    bit          auto_en;
    int          ordy_mode, wr_pct, lmin, lmax;
    int          pend[N], st[N], widx[N], plen[N], req_cyc[N], drop_cyc[N];
    logic [15:0] rte[N];
    logic [1:0]  nbr[N];
    logic        byp[N], prev_ack[N];
    int          lat_ack, lat_drop, last_eop_cyc, max_gap, in_bop_cyc, out_bop_cyc;

    task automatic new_pkt(input int i);
        rte[i]  = 16'($urandom);
        nbr[i]  = 2'($urandom);
        byp[i]  = 1'($urandom);
        plen[i] = int'($urandom_range(lmax, lmin));
        widx[i] = 0;
    endtask

    task automatic load(input int i, input int npk);
        pend[i] = npk;
        st[i]   = 0;
        new_pkt(i);
    endtask

    // Source behaviour: hold req for a packet, write only when rdy, drop req after eop, wait for !ack.
    task automatic agents();
        word_t w;
        out_rdy = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 1) ? (int'($urandom_range(99, 0)) < 70) : 1'b0;
        for (int i = 0; i < N; i++) begin
            src_wr[i]  = 1'b0;
            src_bop[i] = 1'b0;
            src_eop[i] = 1'b0;
            if (src_ack[i] && !prev_ack[i]) begin
                grant_q.push_back(i);
                lat_ack = cyc - req_cyc[i];
            end
            if (st[i] == 0 && pend[i] > 0) begin
                if (!src_req[i]) req_cyc[i] = cyc;
                src_req[i] = 1'b1;
                src_route[16*i +: 16]  = rte[i];
                src_neighbor[2*i +: 2] = nbr[i];
                src_bypass[i]          = byp[i];
                if (src_rdy[i] && int'($urandom_range(99, 0)) < wr_pct) begin
                    w = {{$urandom, $urandom}, widx[i] == 0, widx[i] == plen[i] - 1, rte[i], nbr[i], byp[i]};
                    src_data[64*i +: 64] = w.d;
                    src_wr[i]  = 1'b1;
                    src_bop[i] = w.b;
                    src_eop[i] = w.e;
                    exp_q.push_back(w);
                    if (w.b) begin
                        if (last_eop_cyc >= 0 && cyc - last_eop_cyc > max_gap) max_gap = cyc - last_eop_cyc;
                        if (in_bop_cyc < 0) in_bop_cyc = cyc;
                    end
                    widx[i]++;
                    if (w.e) begin
                        st[i] = 2;
                        last_eop_cyc = cyc;
                    end
                end
            end else if (st[i] == 2) begin
                if (src_req[i]) drop_cyc[i] = cyc;
                src_req[i] = 1'b0;
                if (!src_ack[i]) begin
                    lat_drop = cyc - drop_cyc[i];
                    pend[i]--;
                    st[i] = 0;
                    new_pkt(i);
                end
            end
            prev_ack[i] = src_ack[i];
        end
    endtask

    task automatic mon();
        word_t got;
        if (out_wr && out_rdy) begin
            got = {out_data, out_bop, out_eop, out_route, out_neighbor, out_bypass};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_word_unexpected got=%h exp=none", got);
            end else begin
                if (got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_word got=%h exp=%h", got, exp_q[0]);
                end
                if (exp_q[0].e) exp_pkts++;
                if (exp_q[0].b && out_bop_cyc < 0) out_bop_cyc = cyc;
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic step();
        if (auto_en) agents();
        mon();
        @(negedge clk);
        cyc++;
    endtask

    task automatic mstep();
        step();
        src_wr  = '0;
        src_bop = '0;
        src_eop = '0;
    endtask

    task automatic put(input int i, input logic b, input logic e, input bit acc);
        word_t w;
        w = {{$urandom, $urandom}, b, e, src_route[16*i +: 16], src_neighbor[2*i +: 2], src_bypass[i]};
        src_data[64*i +: 64] = w.d;
        src_wr[i]  = 1'b1;
        src_bop[i] = b;
        src_eop[i] = e;
        if (acc) exp_q.push_back(w);
    endtask

    task automatic run(input int bound);
        int n = 0;
        while ((pend.sum() > 0 || exp_q.size() > 0 || out_wr) && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL run_timeout queued_words=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic clear_agents();
        exp_q.delete();
        grant_q.delete();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            st[i] = 0;
            prev_ack[i] = 1'b0;
        end
        exp_pkts = 0;
        lat_ack = -1;
        lat_drop = -1;
        last_eop_cyc = -1;
        max_gap = 0;
        in_bop_cyc = -1;
        out_bop_cyc = -1;
    endtask

    task automatic do_reset();
        auto_en = 0;
        {src_req, src_wr, src_bop, src_eop, src_bypass} = '0;
        src_data = '0;
        src_route = '0;
        src_neighbor = '0;
        out_rdy = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_agents();
        wr_pct = 100;
        ordy_mode = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (src_ack !== '0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", src_ack); end
        checks++; if (src_rdy !== '0) begin errors++; $display("FAIL reset_rdy got=%0h exp=0", src_rdy); end
        checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr got=%0h exp=0", out_wr); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (err_flags !== 3'd0) begin errors++; $display("FAIL reset_err got=%0h exp=0", err_flags); end
    endtask

    task automatic test_single();
        do_reset();
        lmin = 3;
        lmax = 3;
        load(1, 1);
        auto_en = 1;
        run(100);
        checks++; if (grant_q.size() !== 1) begin errors++; $display("FAIL single_grants got=%0d exp=1", grant_q.size()); end
        else begin checks++; if (grant_q[0] !== 1) begin errors++; $display("FAIL single_grant_src got=%0d exp=1", grant_q[0]); end end
        checks++; if (lat_ack !== 1) begin errors++; $display("FAIL single_ack_latency got=%0d exp=1", lat_ack); end
        checks++; if (lat_drop !== 1) begin errors++; $display("FAIL single_ack_drop got=%0d exp=1", lat_drop); end
        checks++; if (out_bop_cyc - in_bop_cyc !== 1) begin errors++; $display("FAIL single_word_latency got=%0d exp=1", out_bop_cyc - in_bop_cyc); end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_round_robin();
        do_reset();
        lmin = 1;
        lmax = 5;
        for (int i = 0; i < N; i++) load(i, 2);
        auto_en = 1;
        run(400);
        checks++; if (grant_q.size() !== 2 * N) begin errors++; $display("FAIL rr_grants got=%0d exp=%0d", grant_q.size(), 2 * N); end
        for (int k = 0; k < grant_q.size() && k < 2 * N; k++) begin
            checks++;
            if (grant_q[k] !== k % N) begin errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, grant_q[k], k % N); end
        end
        checks++; if (max_gap > 4 || max_gap < 1) begin errors++; $display("FAIL rr_gap got=%0d exp=1..4", max_gap); end
        checks++; if (pkt_count !== 32'(2 * N)) begin errors++; $display("FAIL rr_pkt_count got=%0d exp=%0d", pkt_count, 2 * N); end
        checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL rr_model_pkts got=%0d exp=%0d", pkt_count, exp_pkts); end
    endtask

    task automatic test_backpressure();
        do_reset();
        lmin = 10;
        lmax = 10;
        ordy_mode = 2;
        load(0, 1);
        auto_en = 1;
        repeat (12) step();
        checks++; if (widx[0] !== D) begin errors++; $display("FAIL bp_words_before_stall got=%0d exp=%0d", widx[0], D); end
        checks++; if (src_rdy !== '0) begin errors++; $display("FAIL bp_rdy_low got=%0h exp=0", src_rdy); end
        checks++; if (out_wr !== 1'b1) begin errors++; $display("FAIL bp_held_word got=%0h exp=1", out_wr); end
        ordy_mode = 0;
        run(200);
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL bp_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_errors();
        int n, k;
        do_reset();
        src_route[32 +: 16] = 16'hbeef;
        src_neighbor[4 +: 2] = 2'd2;
        src_bypass[2] = 1'b1;
        src_req = 4'b0100;
        n = 0;
        while (!src_rdy[2] && n < 10) begin mstep(); n++; end
        checks++; if (src_ack !== 4'b0100) begin errors++; $display("FAIL err_ack2 got=%0h exp=4", src_ack); end
        k = 0;
        while (src_rdy[2] && k < 20) begin put(2, k == 0, 1'b0, 1'b1); mstep(); k++; end
        checks++; if (k !== D) begin errors++; $display("FAIL err_words_with_rdy got=%0d exp=%0d", k, D); end
        checks++; if (err_flags !== 3'b000) begin errors++; $display("FAIL err_clean got=%0h exp=0", err_flags); end
        put(2, 1'b0, 1'b0, 1'b1);
        mstep();
        checks++; if (err_flags !== 3'b001) begin errors++; $display("FAIL err_norfy got=%0h exp=1", err_flags); end
        put(2, 1'b0, 1'b0, 1'b0);
        mstep();
        put(3, 1'b1, 1'b0, 1'b0);
        mstep();
        checks++; if (err_flags !== 3'b101) begin errors++; $display("FAIL err_ungranted got=%0h exp=5", err_flags); end
        out_rdy = 1'b1;
        n = 0;
        while (!src_rdy[2] && n < 20) begin mstep(); n++; end
        put(2, 1'b0, 1'b1, 1'b1);
        mstep();
        src_req = '0;
        n = 0;
        while ((exp_q.size() > 0 || out_wr) && n < 50) begin mstep(); n++; end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL err_drain got=%0d exp=0", exp_q.size()); end
        checks++; if (err_flags !== 3'b101) begin errors++; $display("FAIL err_sticky got=%0h exp=5", err_flags); end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL err_pkt_count got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_lost();
        int n;
        do_reset();
        out_rdy = 1'b1;
        src_route[15:0] = 16'h1234;
        src_req = 4'b0001;
        n = 0;
        while (!src_rdy[0] && n < 10) begin mstep(); n++; end
        put(0, 1'b1, 1'b0, 1'b1);
        mstep();
        put(0, 1'b0, 1'b0, 1'b1);
        mstep();
        src_req = '0;
        repeat (3) mstep();
        checks++; if (err_flags !== 3'b010) begin errors++; $display("FAIL lost_err got=%0h exp=2", err_flags); end
        checks++; if (src_ack !== '0) begin errors++; $display("FAIL lost_ack got=%0h exp=0", src_ack); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL lost_words got=%0d exp=0", exp_q.size()); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL lost_pkt_count got=%0d exp=0", pkt_count); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        lmin = 8;
        lmax = 8;
        load(0, 1);
        auto_en = 1;
        while (widx[0] < 4 && n < 50) begin step(); n++; end
        auto_en = 0;
        reset = 1'b1;
        out_rdy = 1'b0;
        src_req = '0;
        src_wr = '0;
        step();
        checks++; if (src_ack !== '0) begin errors++; $display("FAIL rstmid_ack got=%0h exp=0", src_ack); end
        checks++; if (src_rdy !== '0) begin errors++; $display("FAIL rstmid_rdy got=%0h exp=0", src_rdy); end
        checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rstmid_out_wr got=%0h exp=0", out_wr); end
        reset = 1'b0;
        clear_agents();
        out_rdy = 1'b1;
        repeat (3) step();
        checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rstmid_fifo_empty got=%0h exp=0", out_wr); end
        lmin = 5;
        lmax = 5;
        load(3, 1);
        auto_en = 1;
        run(100);
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL rstmid_pkt_count got=%0d exp=1", pkt_count); end
        checks++; if (err_flags !== 3'd0) begin errors++; $display("FAIL rstmid_err got=%0h exp=0", err_flags); end
    endtask

    task automatic test_oversize();
        do_reset();
        lmin = MW;
        lmax = MW;
        load(1, 1);
        auto_en = 1;
        run(1000);
        checks++; if (err_flags !== 3'd0) begin errors++; $display("FAIL max_len_err got=%0h exp=0", err_flags); end
        lmin = MW + 1;
        lmax = MW + 1;
        load(1, 1);
        run(1000);
        checks++; if (err_flags !== 3'b010) begin errors++; $display("FAIL oversize_err got=%0h exp=2", err_flags); end
        checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL oversize_pkt_count got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_random();
        do_reset();
        lmin = 1;
        lmax = 12;
        wr_pct = 70;
        ordy_mode = 1;
        for (int i = 0; i < N; i++) load(i, 3);
        auto_en = 1;
        run(3000);
        checks++; if (pkt_count !== 32'(3 * N)) begin errors++; $display("FAIL rand_pkt_count got=%0d exp=%0d", pkt_count, 3 * N); end
        checks++; if (grant_q.size() !== 3 * N) begin errors++; $display("FAIL rand_grants got=%0d exp=%0d", grant_q.size(), 3 * N); end
        checks++; if (err_flags !== 3'd0) begin errors++; $display("FAIL rand_err got=%0h exp=0", err_flags); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_errors();
        test_lost();
        test_reset_mid();
        test_oversize();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
